trace_recorder: RTL

TRACE_RECORDER -- requirements
Module: trace_recorder

---
 rtl/trace_recorder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/trace_recorder.sv
// Samples the CPU PC plus running stall/flush totals into a small trace FIFO for MAX_CYCLES samples, then drains it.
// A record is valid one cycle after its sampling edge; a full FIFO with no pop drops the sample and counts it.

module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_vld = (count != '0);
  assign pop     = out_vld && out_rdy;
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign in_rdy  = (count != FULL_CNT) || pop;
  assign push    = in_vld && in_rdy;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= in_dat;
  end
endmodule

module trace_recorder #(
  parameter int DEPTH      = 4,
  parameter int MAX_CYCLES = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic [7:0]  drop_cnt_o,
  output logic        done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);
  localparam logic [AW:0] ONE_CNT = (AW+1)'(1);

  typedef struct packed {
    logic [15:0] cycle;
    logic [7:0]  stall;
    logic [7:0]  flush;
    logic [31:0] pc;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic [15:0] cycle_cnt;
  logic [7:0]  stall_tot;
  logic [7:0]  flush_tot;
  logic [7:0]  stall_nxt;
  logic [7:0]  flush_nxt;
  logic        sample;
  logic        fifo_rdy;
  logic        fifo_pop;
  logic [AW:0] fifo_cnt;
  rec_t        rec;

  assign sample    = !rst_i && start_i && ((state == IDLE) || (state == RUN));
  assign stall_nxt = (stall_i && (stall_tot != 8'hff)) ? stall_tot + 8'd1 : stall_tot;
  assign flush_nxt = (flush_i && (flush_tot != 8'hff)) ? flush_tot + 8'd1 : flush_tot;
  assign rec       = '{cycle: cycle_cnt, stall: stall_nxt, flush: flush_nxt, pc: pc_i};
  assign fifo_pop  = out_valid_o && out_ready_i;

  trace_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_vld  (sample),
    .in_rdy  (fifo_rdy),
    .in_dat  (rec),
    .out_vld (out_valid_o),
    .out_rdy (out_ready_i),
    .out_dat (out_data_o),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      stall_tot  <= '0;
      flush_tot  <= '0;
      drop_cnt_o <= '0;
      done_o     <= 1'b0;
    end else begin
      // Dropped samples still advance all counters and count toward MAX_CYCLES.
      if (sample) begin
        cycle_cnt <= cycle_cnt + 16'd1;
        stall_tot <= stall_nxt;
        flush_tot <= flush_nxt;
        if (!fifo_rdy && (drop_cnt_o != 8'hff)) drop_cnt_o <= drop_cnt_o + 8'd1;
      end
      case (state)
        IDLE, RUN: begin
          if (sample) state <= (cycle_cnt == LAST_CYCLE) ? DRAIN : RUN;
        end
        DRAIN: begin
          if ((fifo_cnt == '0) || ((fifo_cnt == ONE_CNT) && fifo_pop)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
